// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage. It owns the HI/LO registers and
// processes one operand bit per cycle: shift-add for multiply, restoring subtract for divide.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [4:0] MULT_OP  = 5'b00110,
  parameter logic [4:0] MULTU_OP = 5'b00111,
  parameter logic [4:0] DIV_OP   = 5'b01000,
  parameter logic [4:0] DIVU_OP  = 5'b01001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_ctrl_out,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divideZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             is_mult_code;
  logic             is_div_code;
  logic             is_signed_code;
  logic             accept;
  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative operand stays exact.
  always_comb begin
    is_mult_code   = (alu_ctrl_out == MULT_OP) || (alu_ctrl_out == MULTU_OP);
    is_div_code    = (alu_ctrl_out == DIV_OP)  || (alu_ctrl_out == DIVU_OP);
    is_signed_code = (alu_ctrl_out == MULT_OP) || (alu_ctrl_out == DIV_OP);
    accept         = start && ((state == IDLE) || (state == DONE)) && (is_mult_code || is_div_code);
    op1_neg        = is_signed_code && op1[WIDTH-1];
    op2_neg        = is_signed_code && op2[WIDTH-1];
    op1_mag        = op1_neg ? (~op1 + 1'b1) : op1;
    op2_mag        = op2_neg ? (~op2 + 1'b1) : op2;
  end

  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_fits   = (div_shift >= {1'b0, mag_b});
    prod_fixed = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    quo_fixed  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    rem_fixed  = neg_r ? (~acc_hi + 1'b1) : acc_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      mag_b      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      divideZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            divideZero <= 1'b0;
            is_div     <= is_div_code;
            neg_q      <= op1_neg ^ op2_neg;
            neg_r      <= op1_neg;
            count      <= '0;
            acc_hi     <= '0;
            acc_lo     <= is_div_code ? op1_mag : op2_mag;
            mag_b      <= is_div_code ? op2_mag : op1_mag;
            // A zero divisor skips the iteration entirely and leaves HI/LO untouched.
            if (is_div_code && (op2 == '0)) begin
              state      <= DONE;
              done       <= 1'b1;
              divideZero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc_hi <= div_fits ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div) begin
              hi <= rem_fixed;
              lo <= quo_fixed;
            end else begin
              {hi, lo} <= prod_fixed;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a behavioural model pushes expected HI/LO/divideZero
// into a scoreboard queue at issue time, and entries are popped when done pulses.
`timescale 1ns/1ps
module tb_mult_div_unit;

  localparam logic [4:0] MULT  = 5'b00110;
  localparam logic [4:0] MULTU = 5'b00111;
  localparam logic [4:0] DIV   = 5'b01000;
  localparam logic [4:0] DIVU  = 5'b01001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  alu_ctrl_out;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divideZero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        scoreboard[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        model_dz = 1'b0;

  mult_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .alu_ctrl_out (alu_ctrl_out),
    .op1          (op1),
    .op2          (op2),
    .flush        (flush),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .divideZero   (divideZero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on 64-bit integers; SV division truncates toward zero like the unit.
  task automatic push_expected(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    exp_t        e;
    sa  = $signed(a);
    sbv = $signed(b);
    model_dz = 1'b0;
    case (code)
      MULT: begin
        p = sa * sbv;
        {model_hi, model_lo} = p;
      end
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {model_hi, model_lo} = p;
      end
      DIV: begin
        if (b == 0) model_dz = 1'b1;
        else begin
          q = sa / sbv;
          r = sa % sbv;
          model_lo = q[31:0];
          model_hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) model_dz = 1'b1;
        else begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
    endcase
    e.hi = model_hi;
    e.lo = model_lo;
    e.dz = model_dz;
    scoreboard.push_back(e);
  endtask

  // Issues one operation at a negedge and watches it cycle by cycle (cycle 0 = start cycle).
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit stop_at_done, input int inject_cycle);
    bit   exp_dz;
    int   done_cycle = -1;
    int   done_cnt   = 0;
    int   busy_bad   = 0;
    int   exp_done;
    exp_t e;
    exp_dz   = ((code == DIV) || (code == DIVU)) && (b == 0);
    exp_done = exp_dz ? 1 : 34;
    push_expected(code, a, b);
    start = 1'b1; alu_ctrl_out = code; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; alu_ctrl_out = 5'b00000; op1 = $urandom; op2 = $urandom;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (busy !== (!exp_dz && c <= 33)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = c;
          if (scoreboard.size() == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL scoreboard_empty: done seen in cycle %0d with no expected entry", c);
          end else begin
            e = scoreboard.pop_front();
            n_checks++;
            if (hi !== e.hi) begin
              n_fail++;
              $display("[TB] FAIL hi op=%b a=%h b=%h: got %h expected %h", code, a, b, hi, e.hi);
            end
            n_checks++;
            if (lo !== e.lo) begin
              n_fail++;
              $display("[TB] FAIL lo op=%b a=%h b=%h: got %h expected %h", code, a, b, lo, e.lo);
            end
            n_checks++;
            if (divideZero !== e.dz) begin
              n_fail++;
              $display("[TB] FAIL divideZero op=%b: got %b expected %b", code, divideZero, e.dz);
            end
          end
        end
      end
      if (c == inject_cycle) begin
        start = 1'b1; alu_ctrl_out = MULTU; op1 = 32'd9; op2 = 32'd9;
      end
      if (c == inject_cycle + 1) begin
        start = 1'b0; alu_ctrl_out = 5'b00000;
      end
      if (stop_at_done && done_cycle >= 0) break;
    end
    n_checks++;
    if (done_cycle !== exp_done) begin
      n_fail++;
      $display("[TB] FAIL done_latency op=%b: got cycle %0d expected cycle %0d", code, done_cycle, exp_done);
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("[TB] FAIL done_pulses op=%b: got %0d expected 1", code, done_cnt);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL busy_window op=%b: got %0d wrong cycles expected 0", code, busy_bad);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_ctrl_out = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, divideZero} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, divideZero});
    end
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
  endtask

  task automatic test_mult;
    run_op(MULT,  32'hFFFF_FFFD, 32'd5, 1'b0, -1);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, -1);
    run_op(MULT,  32'h8000_0000, 32'h0000_0001, 1'b0, -1);
  endtask

  task automatic test_div;
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(DIV,  32'd7, 32'hFFFF_FFFE, 1'b0, -1);
    run_op(DIVU, 32'd7, 32'd2, 1'b0, -1);
  endtask

  // Relies on test_div ending with DIVU 7/2 so the held values are hi=1, lo=3.
  task automatic test_div_zero;
    run_op(DIV, 32'd5, 32'd0, 1'b0, -1);
    n_checks++;
    if ({hi, lo} !== {32'd1, 32'd3}) begin
      n_fail++;
      $display("[TB] FAIL div_zero_hold: got %h expected %h", {hi, lo}, {32'd1, 32'd3});
    end
    run_op(MULTU, 32'd2, 32'd3, 1'b0, -1);
    n_checks++;
    if (divideZero !== 1'b0 || lo !== 32'd6) begin
      n_fail++;
      $display("[TB] FAIL div_zero_clear: got dz=%b lo=%h expected dz=0 lo=6", divideZero, lo);
    end
  endtask

  task automatic test_invalid_code;
    int seen = 0;
    start = 1'b1; alu_ctrl_out = 5'b00010; op1 = 32'd4; op2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0 || {hi, lo} !== {model_hi, model_lo}) begin
      n_fail++;
      $display("[TB] FAIL invalid_code: got %0d active cycles hilo=%h expected 0 and %h", seen, {hi, lo}, {model_hi, model_lo});
    end
  endtask

  task automatic test_start_while_busy;
    run_op(MULT, 32'd2, 32'd3, 1'b0, 5);
  endtask

  task automatic test_flush(input int flush_cycle, input bit with_start);
    int done_cnt = 0;
    int busy_bad = 0;
    start = 1'b1; alu_ctrl_out = MULT; op1 = 32'd7; op2 = 32'd11;
    model_dz = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; alu_ctrl_out = 5'b00000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (c > flush_cycle && busy !== 1'b0) busy_bad++;
      if (c == flush_cycle) begin
        flush = 1'b1;
        if (with_start) begin
          start = 1'b1; alu_ctrl_out = MULTU; op1 = 32'd9; op2 = 32'd9;
        end
      end
      if (c == flush_cycle + 1) begin
        flush = 1'b0; start = 1'b0; alu_ctrl_out = 5'b00000;
      end
    end
    n_checks++;
    if (done_cnt !== 0 || busy_bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL flush_idle at %0d: got done=%0d busy=%0d expected 0 and 0", flush_cycle, done_cnt, busy_bad);
    end
    n_checks++;
    if ({hi, lo, divideZero} !== {model_hi, model_lo, model_dz}) begin
      n_fail++;
      $display("[TB] FAIL flush_hold at %0d: got %h expected %h", flush_cycle, {hi, lo, divideZero}, {model_hi, model_lo, model_dz});
    end
  endtask

  task automatic test_reset_mid_op;
    int done_cnt = 0;
    start = 1'b1; alu_ctrl_out = MULTU; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0; alu_ctrl_out = 5'b00000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (c == 20) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, divideZero, hi, lo} !== 67'h0) begin
          n_fail++;
          $display("[TB] FAIL reset_mid_op: got %h expected 0", {busy, done, divideZero, hi, lo});
        end
      end
      if (c == 21) rst = 1'b0;
    end
    model_hi = '0; model_lo = '0; model_dz = 1'b0;
    n_checks++;
    if (done_cnt !== 0 || {hi, lo} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_after: got done=%0d hilo=%h expected 0 and 0", done_cnt, {hi, lo});
    end
  endtask

  task automatic test_back_to_back;
    run_op(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, -1);
    run_op(DIV,   32'hF000_0001, 32'd13, 1'b1, -1);
    run_op(DIVU,  32'hFFFF_FFFF, 32'd10, 1'b0, -1);
  endtask

  task automatic test_random;
    logic [4:0]  code;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: code = MULT;
        1: code = MULTU;
        2: code = DIV;
        default: code = DIVU;
      endcase
      a = $urandom;
      b = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd3;
      if (i[0]) b = -b;
      run_op(code, a, b, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_invalid_code();
    test_start_while_busy();
    test_flush(10, 1'b0);
    test_flush(33, 1'b1);
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    n_checks++;
    if (scoreboard.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", scoreboard.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
